// File: rtl/reset_sequencer_if.sv
// Control/status bundle of the reset sequencer: software/watchdog requests in,
// staggered channel resets and status out.
interface reset_sequencer_if #(
  parameter int NCH = 3
);
  logic           SW_RST_I;
  logic           WDT_EN_I;
  logic           WDT_KICK_I;
  logic [NCH-1:0] RST_N_O;
  logic           READY_O;
  logic           WDT_FIRED_O;
  logic [1:0]     CAUSE_O;

  modport master (
    output SW_RST_I, WDT_EN_I, WDT_KICK_I,
    input  RST_N_O, READY_O, WDT_FIRED_O, CAUSE_O
  );

  modport slave (
    input  SW_RST_I, WDT_EN_I, WDT_KICK_I,
    output RST_N_O, READY_O, WDT_FIRED_O, CAUSE_O
  );
endinterface

// File: rtl/reset_sequencer.sv
// Synchronised, staggered release of NCH active-low resets with software
// re-sequence and a watchdog that re-enters the sequence on timeout.
module reset_sequencer #(
  parameter int NCH         = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD        = 4,
  parameter int STAGGER     = 2,
  parameter int WDT_CYCLES  = 10
) (
  input  logic                CLK_I,
  input  logic                RST_N_I,
  reset_sequencer_if.slave    bus
);
  localparam int MAX_HS = (HOLD > STAGGER) ? HOLD : STAGGER;
  localparam int MAXC   = (MAX_HS > WDT_CYCLES) ? MAX_HS : WDT_CYCLES;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);
  localparam logic [CW-1:0] STG_LAST  = CW'(STAGGER - 1);
  localparam logic [CW-1:0] WDT_LAST  = CW'(WDT_CYCLES - 1);
  localparam logic [IW-1:0] LAST_CH   = IW'(NCH - 1);
  // With no stagger (or a single channel) everything releases on the HOLD expiry edge.
  localparam bit ALL_AT_ONCE = (STAGGER == 0) || (NCH == 1);

  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN} state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          r_wdt;
  logic [IW-1:0]          r_idx;
  logic [NCH-1:0]         r_rst_n;
  logic                   r_ready;
  logic                   r_fired;
  logic [1:0]             r_cause;
  logic                   w_synced;
  logic                   w_expire;

  assign w_synced = r_sync[SYNC_STAGES-1];
  // A kick on the expiry edge clears the count instead of firing.
  assign w_expire = (r_state == S_RUN) && bus.WDT_EN_I && !bus.WDT_KICK_I &&
                    (r_wdt == WDT_LAST);

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_wdt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
      r_fired <= 1'b0;
      r_cause <= 2'b00;
    end else if (bus.SW_RST_I) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_wdt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
      r_cause <= 2'b01;
    end else if (w_expire) begin
      // Sync chain is left alone: the input reset is already released.
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_wdt   <= '0;
      r_idx   <= '0;
      r_rst_n <= '0;
      r_ready <= 1'b0;
      r_fired <= 1'b1;
      r_cause <= 2'b10;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (w_synced) begin
            if (r_cnt == HOLD_LAST) begin
              r_cnt <= '0;
              if (ALL_AT_ONCE) begin
                r_rst_n <= '1;
                r_ready <= 1'b1;
                r_wdt   <= '0;
                r_state <= S_RUN;
              end else begin
                r_rst_n <= NCH'(1);
                r_idx   <= IW'(1);
                r_state <= S_RELEASE;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_RELEASE: begin
          if (r_cnt == STG_LAST) begin
            r_cnt          <= '0;
            r_rst_n[r_idx] <= 1'b1;
            if (r_idx == LAST_CH) begin
              r_ready <= 1'b1;
              r_wdt   <= '0;
              r_state <= S_RUN;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_RUN: begin
          if (!bus.WDT_EN_I || bus.WDT_KICK_I) r_wdt <= '0;
          else                                 r_wdt <= r_wdt + CW'(1);
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

  assign bus.RST_N_O     = r_rst_n;
  assign bus.READY_O     = r_ready;
  assign bus.WDT_FIRED_O = r_fired;
  assign bus.CAUSE_O     = r_cause;
endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: expected output vectors {RST_N_O,READY_O,WDT_FIRED_O,CAUSE_O}
// are queued per edge with the stimulus and compared #1 after that edge.
module tb_reset_sequencer;
  logic CLK_I = 1'b0;
  logic RST_N_I = 1'b0;

  reset_sequencer_if #(.NCH(3)) bus ();

  reset_sequencer #(
    .NCH(3), .SYNC_STAGES(2), .HOLD(4), .STAGGER(2), .WDT_CYCLES(10)
  ) dut (
    .CLK_I  (CLK_I),
    .RST_N_I(RST_N_I),
    .bus    (bus)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    int         edge_n;
    string      tag;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   base  = 0;
  int   n_chk = 0;
  int   n_err = 0;

  function automatic logic [6:0] outs();
    return {bus.RST_N_O, bus.READY_O, bus.WDT_FIRED_O, bus.CAUSE_O};
  endfunction

  task automatic chk(input string tag, input logic [6:0] act, input logic [6:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got rst_n/rdy/fired/cause=%b_%b_%b_%b want %b_%b_%b_%b",
               tag, act[6:4], act[3], act[2], act[1:0], exp[6:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Expectation at edge n relative to the current power-on base.
  task automatic push(input int n, input string tag, input logic [2:0] r,
                      input logic rd, input logic f, input logic [1:0] c);
    exp_t e;
    int   i;
    e.edge_n = base + n;
    e.tag    = tag;
    e.v      = {r, rd, f, c};
    i = 0;
    while (i < sb.size() && sb[i].edge_n <= e.edge_n) i++;
    sb.insert(i, e);
  endtask

  // Return in the low phase just before relative edge n.
  task automatic upto(input int n);
    while (cyc < base + n - 1) @(negedge CLK_I);
  endtask

  always begin
    exp_t e;
    @(posedge CLK_I);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].edge_n <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, outs(), e.v);
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1, "timeout");
  end

  initial begin
    bus.SW_RST_I   = 1'b0;
    bus.WDT_EN_I   = 1'b1;
    bus.WDT_KICK_I = 1'b0;
    repeat (3) @(negedge CLK_I);
    chk("reset_state", outs(), 7'b000_0_0_00);

    // Power-on: release between edge base and base+1.
    base = cyc;
    push(1,  "por_e1",  3'b000, 0, 0, 2'b00);
    push(5,  "por_e5",  3'b000, 0, 0, 2'b00);
    push(6,  "por_e6",  3'b001, 0, 0, 2'b00);
    push(7,  "por_e7",  3'b001, 0, 0, 2'b00);
    push(8,  "por_e8",  3'b011, 0, 0, 2'b00);
    push(9,  "por_e9",  3'b011, 0, 0, 2'b00);
    push(10, "por_e10", 3'b111, 1, 0, 2'b00);
    push(19, "run_e19", 3'b111, 1, 0, 2'b00);
    // SW on the watchdog expiry edge: software wins, fired stays 0.
    push(20, "collide", 3'b000, 0, 0, 2'b01);
    push(23, "col_e23", 3'b000, 0, 0, 2'b01);
    push(24, "col_e24", 3'b001, 0, 0, 2'b01);
    push(26, "col_e26", 3'b011, 0, 0, 2'b01);
    push(28, "col_e28", 3'b111, 1, 0, 2'b01);
    push(37, "run_e37", 3'b111, 1, 0, 2'b01);
    push(38, "wdt_fire", 3'b000, 0, 1, 2'b10);
    push(41, "wdt_e41", 3'b000, 0, 1, 2'b10);
    push(42, "wdt_e42", 3'b001, 0, 1, 2'b10);
    push(44, "wdt_e44", 3'b011, 0, 1, 2'b10);
    push(46, "wdt_e46", 3'b111, 1, 1, 2'b10);
    push(55, "kick_e55", 3'b111, 1, 1, 2'b10);
    push(56, "kick_exp", 3'b111, 1, 1, 2'b10);
    push(57, "kick_e57", 3'b111, 1, 1, 2'b10);
    push(66, "kick_e66", 3'b111, 1, 1, 2'b10);
    push(75, "kick_e75", 3'b111, 1, 1, 2'b10);
    push(84, "kick_e84", 3'b111, 1, 1, 2'b10);
    push(95, "wdt_off", 3'b111, 1, 1, 2'b10);
    push(100, "sw_e100", 3'b000, 0, 1, 2'b01);
    push(103, "sw_e103", 3'b000, 0, 1, 2'b01);
    push(104, "sw_e104", 3'b001, 0, 1, 2'b01);
    push(105, "swh_e105", 3'b000, 0, 1, 2'b01);
    push(107, "swh_e107", 3'b000, 0, 1, 2'b01);
    push(110, "swh_e110", 3'b000, 0, 1, 2'b01);
    push(111, "swh_e111", 3'b001, 0, 1, 2'b01);
    push(113, "swh_e113", 3'b011, 0, 1, 2'b01);
    push(114, "swh_e114", 3'b011, 0, 1, 2'b01);
    push(115, "swh_e115", 3'b111, 1, 1, 2'b01);
    push(120, "sw2_e120", 3'b000, 0, 1, 2'b01);
    push(124, "sw2_e124", 3'b001, 0, 1, 2'b01);
    push(125, "sw2_e125", 3'b001, 0, 1, 2'b01);
    RST_N_I = 1'b1;

    upto(20); bus.SW_RST_I = 1'b1;
    upto(21); bus.SW_RST_I = 1'b0;
    upto(56); bus.WDT_KICK_I = 1'b1;
    upto(57); bus.WDT_KICK_I = 1'b0;
    for (int k = 65; k <= 83; k += 9) begin
      upto(k);     bus.WDT_KICK_I = 1'b1;
      upto(k + 1); bus.WDT_KICK_I = 1'b0;
    end
    upto(90);  bus.WDT_EN_I = 1'b0;
    upto(100); bus.SW_RST_I = 1'b1;
    upto(101); bus.SW_RST_I = 1'b0;
    upto(105); bus.SW_RST_I = 1'b1;
    upto(108); bus.SW_RST_I = 1'b0;
    upto(120); bus.SW_RST_I = 1'b1;
    upto(121); bus.SW_RST_I = 1'b0;

    // Asynchronous reset in the middle of RELEASE, one-cycle glitch.
    upto(126);
    RST_N_I = 1'b0;
    #1;
    chk("async_rst", outs(), 7'b000_0_0_00);
    upto(127);
    chk("async_hold", outs(), 7'b000_0_0_00);
    base = cyc;
    push(5,  "gl_e5",  3'b000, 0, 0, 2'b00);
    push(6,  "gl_e6",  3'b001, 0, 0, 2'b00);
    push(8,  "gl_e8",  3'b011, 0, 0, 2'b00);
    push(9,  "gl_e9",  3'b011, 0, 0, 2'b00);
    push(10, "gl_e10", 3'b111, 1, 0, 2'b00);
    RST_N_I = 1'b1;
    upto(13);

    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
